// File: rtl/random_byte_gen.sv
// Pseudo-random byte source on a 32-bit right-shift Galois LFSR, STEPS_PER_CLK steps per clock.
// o_data is taken straight from the state register; there is no handshake and it never stalls.
module random_byte_gen #(
    parameter int          STEPS_PER_CLK = 8,
    parameter logic [31:0] POLY          = 32'h80200003,
    parameter logic [31:0] DEFAULT_SEED  = 32'h00000001
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_seed,
    output logic [7:0]  o_data
);

    generate
        if (STEPS_PER_CLK < 1 || STEPS_PER_CLK > 32) begin : g_bad_steps
            $error("STEPS_PER_CLK must be in 1..32");
        end
        if (DEFAULT_SEED == 32'h0) begin : g_bad_seed
            $error("DEFAULT_SEED must be nonzero");
        end
    endgenerate

    logic [31:0] r_state;
    logic [31:0] w_stepped;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) begin
            n = n ^ POLY;
        end
        return n;
    endfunction

    // Fully unrolled in one cycle so each clock advances STEPS_PER_CLK single steps.
    always_comb begin
        w_stepped = r_state;
        for (int i = 0; i < STEPS_PER_CLK; i++) begin
            w_stepped = lfsr_step(w_stepped);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= (i_seed == 32'h0) ? DEFAULT_SEED : i_seed;
        end else if (r_state == 32'h0) begin
            // All-zero is the LFSR's lockup state; only an upset can get here.
            r_state <= DEFAULT_SEED;
        end else begin
            r_state <= w_stepped;
        end
    end

    assign o_data = r_state[7:0];

endmodule

// File: tb/tb_random_byte_gen.sv
// Scoreboard bench for random_byte_gen: default-parameter instance plus a single-step instance.
module tb_random_byte_gen;

    localparam logic [31:0] POLY = 32'h80200003;

    logic        clk;
    logic        rst, rst1;
    logic [31:0] seed, seed1;
    logic [7:0]  o_data, o_data1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] sb_q[$];
    logic [31:0] m_state;

    random_byte_gen dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_seed  (seed),
        .o_data  (o_data)
    );

    random_byte_gen #(.STEPS_PER_CLK(1)) dut1 (
        .i_clk   (clk),
        .i_reset (rst1),
        .i_seed  (seed1),
        .o_data  (o_data1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] f1(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ POLY;
        return n;
    endfunction

    function automatic logic [31:0] f8(input logic [31:0] s);
        logic [31:0] n;
        n = s;
        for (int k = 0; k < 8; k++) n = f1(n);
        return n;
    endfunction

    // Drive one cycle's inputs on the falling edge and wait for the next falling edge.
    task automatic cycle(input logic r, input logic [31:0] s);
        rst  = r;
        seed = s;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] exp;
        logic [31:0] tbl [4];
        tbl[0] = 32'h80200003; tbl[1] = 32'hC0300002;
        tbl[2] = 32'h60180001; tbl[3] = 32'hB02C0003;
        for (int i = 0; i < 2; i++) begin
            rst1 = 1'b1; seed1 = 32'h00000001;
            sb_q.push_back(32'h00000001);
            @(negedge clk);
            exp = sb_q.pop_front();
            n_checks++;
            if (dut1.r_state !== exp || o_data1 !== exp[7:0])
                $display("FAIL reset1_state cyc%0d: state=%h o_data=%h, expected %h/%h",
                         i, dut1.r_state, o_data1, exp, exp[7:0]);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            rst1 = 1'b0;
            sb_q.push_back(tbl[i]);
            @(negedge clk);
            exp = sb_q.pop_front();
            n_checks++;
            if (dut1.r_state !== exp || o_data1 !== exp[7:0])
                $display("FAIL step1_seq cyc%0d: state=%h o_data=%h, expected %h/%h",
                         i, dut1.r_state, o_data1, exp, exp[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_zero_seed;
        logic [31:0] exp;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(32'h00000001);
            cycle(1'b1, 32'h00000000);
            exp = sb_q.pop_front();
            n_checks++;
            if (dut.r_state !== exp || o_data !== 8'h01)
                $display("FAIL zero_seed_reset cyc%0d: state=%h o_data=%h, expected %h/01",
                         i, dut.r_state, o_data, exp);
            else n_pass++;
        end
        m_state = 32'h00000001;
        for (int i = 0; i < 20; i++) begin
            m_state = f8(m_state);
            sb_q.push_back(m_state);
            cycle(1'b0, 32'h00000000);
            exp = sb_q.pop_front();
            n_checks++;
            if (dut.r_state !== exp || o_data !== exp[7:0])
                $display("FAIL zero_seed_run cyc%0d: state=%h o_data=%h, expected %h/%h",
                         i, dut.r_state, o_data, exp, exp[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_long_run;
        logic [31:0] exp;
        sb_q.push_back(32'hABCDEF01);
        cycle(1'b1, 32'hABCDEF01);
        exp = sb_q.pop_front();
        n_checks++;
        if (dut.r_state !== exp || o_data !== 8'h01)
            $display("FAIL long_reset: state=%h o_data=%h, expected %h/01", dut.r_state, o_data, exp);
        else n_pass++;
        m_state = 32'hABCDEF01;
        for (int i = 0; i < 1000; i++) begin
            m_state = f8(m_state);
            sb_q.push_back(m_state);
            cycle(1'b0, 32'hABCDEF01);
            exp = sb_q.pop_front();
            n_checks++;
            if (dut.r_state !== exp || o_data !== exp[7:0] || dut.r_state === 32'h0)
                $display("FAIL long_run cyc%0d: state=%h o_data=%h, expected %h/%h",
                         i, dut.r_state, o_data, exp, exp[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_midrun_reset;
        logic [31:0] exp;
        sb_q.push_back(32'h12345678);
        cycle(1'b1, 32'h12345678);
        exp = sb_q.pop_front();
        n_checks++;
        if (dut.r_state !== exp || o_data !== 8'h78)
            $display("FAIL midrun_reseed: state=%h o_data=%h, expected %h/78", dut.r_state, o_data, exp);
        else n_pass++;
        m_state = 32'h12345678;
        for (int i = 0; i < 50; i++) begin
            m_state = f8(m_state);
            sb_q.push_back(m_state);
            cycle(1'b0, 32'h12345678);
            exp = sb_q.pop_front();
            n_checks++;
            if (dut.r_state !== exp || o_data !== exp[7:0])
                $display("FAIL midrun_seq cyc%0d: state=%h o_data=%h, expected %h/%h",
                         i, dut.r_state, o_data, exp, exp[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_seed_toggle;
        logic [31:0] exp;
        sb_q.push_back(32'h5AA5C33C);
        cycle(1'b1, 32'h5AA5C33C);
        exp = sb_q.pop_front();
        n_checks++;
        if (dut.r_state !== exp)
            $display("FAIL toggle_reset: state=%h, expected %h", dut.r_state, exp);
        else n_pass++;
        m_state = 32'h5AA5C33C;
        for (int i = 0; i < 200; i++) begin
            m_state = f8(m_state);
            sb_q.push_back(m_state);
            cycle(1'b0, $urandom);
            exp = sb_q.pop_front();
            n_checks++;
            if (dut.r_state !== exp || o_data !== exp[7:0])
                $display("FAIL seed_toggle cyc%0d: state=%h o_data=%h, expected %h/%h",
                         i, dut.r_state, o_data, exp, exp[7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_lockup;
        logic [31:0] exp;
        rst  = 1'b0;
        seed = 32'hDEADBEEF;
        force dut.r_state = 32'h0;
        #1;
        release dut.r_state;
        #1;
        n_checks++;
        if (o_data !== 8'h00)
            $display("FAIL lockup_deposit: o_data=%h, expected 00", o_data);
        else n_pass++;
        sb_q.push_back(32'h00000001);
        @(negedge clk);
        exp = sb_q.pop_front();
        n_checks++;
        if (dut.r_state !== exp || o_data !== 8'h01)
            $display("FAIL lockup_recover: state=%h o_data=%h, expected %h/01", dut.r_state, o_data, exp);
        else n_pass++;
        m_state = 32'h00000001;
        for (int i = 0; i < 5; i++) begin
            m_state = f8(m_state);
            sb_q.push_back(m_state);
            cycle(1'b0, 32'hDEADBEEF);
            exp = sb_q.pop_front();
            n_checks++;
            if (dut.r_state !== exp || o_data !== exp[7:0])
                $display("FAIL lockup_after cyc%0d: state=%h o_data=%h, expected %h/%h",
                         i, dut.r_state, o_data, exp, exp[7:0]);
            else n_pass++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        seed  = 32'h00000001;
        rst1  = 1'b1;
        seed1 = 32'h00000001;
        @(negedge clk);
        test_reset();
        test_zero_seed();
        test_long_run();
        test_midrun_reset();
        test_seed_toggle();
        test_lockup();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
